sync_fifo_param: RTL and testbench



---
 rtl/sync_fifo_param.sv | 135 +++++++++++++
 tb/tb_sync_fifo_param.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param
// Description : Parametrised single-clock FIFO with occupancy count,
//               programmable almost-full / almost-empty thresholds and
//               sticky overflow / underflow flags with explicit clear.
//               Optional macro SYNC_FIFO_FWFT_EN selects first-word-fall-
//               through read; otherwise data_out is a registered read
//               with one cycle of latency.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module sync_fifo_param #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd,
    output logic [DATA_W-1:0] data_out,
    input  logic [ADDR_W:0]   af_thresh,
    input  logic [ADDR_W:0]   ae_thresh,
    input  logic              clr_err,
    output logic [ADDR_W:0]   fifo_count,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              fifo_almost_full,
    output logic              fifo_almost_empty,
    output logic              fifo_overflow,
    output logic              fifo_underflow
);

    localparam logic [ADDR_W:0] c_one   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wptr;
    logic [ADDR_W:0]   r_rptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_full;
    logic              w_empty;
    logic              w_rd_acc;
    logic              w_wr_acc;

    // Status flags decode straight from the registered count and thresholds
    assign w_full   = (r_count == c_depth);
    assign w_empty  = (r_count == '0);

    // A read frees a slot in the same cycle, so a full FIFO still accepts a
    // write that coincides with an accepted read (pass-through case)
    assign w_rd_acc = rd & ~w_empty;
    assign w_wr_acc = wr & (~w_full | w_rd_acc);

    // Storage array: written on accepted writes only, never cleared by reset
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[r_wptr[ADDR_W-1:0]] <= data_in;
        end
    end

    // Pointers and occupancy counter; count is tracked independently of the
    // pointer difference so flags decode from a single register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + c_one;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + c_one;
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + c_one;
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - c_one;
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rd && !w_rd_acc) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is always presented; rd only acknowledges and advances rptr
    assign data_out = r_mem[r_rptr[ADDR_W-1:0]];
`else
    logic [DATA_W-1:0] r_data_out;

    // Registered read: the word leaves the array on the accepting edge and
    // is held until the next accepted read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
        end else if (w_rd_acc) begin
            r_data_out <= r_mem[r_rptr[ADDR_W-1:0]];
        end
    end

    assign data_out = r_data_out;
`endif

    assign fifo_count        = r_count;
    assign fifo_full         = w_full;
    assign fifo_empty        = w_empty;
    assign fifo_almost_full  = (r_count >= af_thresh);
    assign fifo_almost_empty = (r_count <= ae_thresh);
    assign fifo_overflow     = r_overflow;
    assign fifo_underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_param
// Description : Directed plus randomised scoreboard bench for
//               sync_fifo_param (DEPTH=16, DATA_W=8). Honours
//               SYNC_FIFO_FWFT_EN when the design is built with it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic [4:0] af_thresh = 5'd14;
    logic [4:0] ae_thresh = 5'd2;
    logic [4:0] fifo_count;
    logic       fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty;
    logic       fifo_overflow, fifo_underflow;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: own pointers, data queue, read register, sticky flags
    logic [4:0] m_wptr = '0;
    logic [4:0] m_rptr = '0;
    logic [7:0] m_q[$];
    logic [7:0] m_dout = '0;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    sync_fifo_param #(.DATA_W(8), .DEPTH(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .wr                (wr),
        .data_in           (data_in),
        .rd                (rd),
        .data_out          (data_out),
        .af_thresh         (af_thresh),
        .ae_thresh         (ae_thresh),
        .clr_err           (clr_err),
        .fifo_count        (fifo_count),
        .fifo_full         (fifo_full),
        .fifo_empty        (fifo_empty),
        .fifo_almost_full  (fifo_almost_full),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_overflow     (fifo_overflow),
        .fifo_underflow    (fifo_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [4:0] cnt;
        cnt = m_wptr - m_rptr;
        chk("count", 32'(fifo_count), 32'(cnt));
        chk("full", 32'(fifo_full), 32'(cnt == 5'd16));
        chk("empty", 32'(fifo_empty), 32'(cnt == 5'd0));
        chk("almost_full", 32'(fifo_almost_full), 32'(cnt >= af_thresh));
        chk("almost_empty", 32'(fifo_almost_empty), 32'(cnt <= ae_thresh));
        chk("overflow", 32'(fifo_overflow), 32'(m_ovf));
        chk("underflow", 32'(fifo_underflow), 32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
        if (cnt != 5'd0) chk("data_out_head", 32'(data_out), 32'(m_q[0]));
`else
        chk("data_out", 32'(data_out), 32'(m_dout));
`endif
    endtask

    // One clock cycle with the given request pattern, then model update and check
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        logic [4:0] cnt;
        logic       racc, wacc;
        cnt  = m_wptr - m_rptr;
        racc = r && (cnt != 5'd0);
        wacc = w && ((cnt != 5'd16) || racc);
        wr = w; data_in = d; rd = r; clr_err = c;
        @(posedge clk); #1;
        if (racc) begin
            m_dout = m_q.pop_front();
            m_rptr = m_rptr + 5'd1;
        end
        if (wacc) begin
            m_q.push_back(d);
            m_wptr = m_wptr + 5'd1;
        end
        if (w && !wacc) m_ovf = 1'b1;
        else if (c)     m_ovf = 1'b0;
        if (r && !racc) m_unf = 1'b1;
        else if (c)     m_unf = 1'b0;
        wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
        check_all();
    endtask

    // Reset while requests are active: reset must override them
    task automatic do_reset();
        rst = 1'b1; wr = 1'b1; rd = 1'b1; clr_err = 1'b0; data_in = 8'hFF;
        @(posedge clk); #1;
        rst = 1'b0; wr = 1'b0; rd = 1'b0;
        m_wptr = '0; m_rptr = '0; m_q.delete(); m_dout = '0;
        m_ovf = 1'b0; m_unf = 1'b0;
        check_all();
    endtask

    initial begin
        // Reset with af_thresh=0 so almost_full must read 1 on an empty FIFO
        af_thresh = 5'd0;
        do_reset();
        af_thresh = 5'd14;
        #1 check_all();

        // Fill with 0x00..0x0F
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);

        // Rejected write on full, hold, clear, then clear colliding with error
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Full pass-through read+write
        step(1'b1, 8'hA5, 1'b1, 1'b0);

        // Drain: 0x01..0x0F then 0xA5
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Empty: lone read underflows, then read+write is write-only
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Randomised interleaving across the whole occupancy range
        for (int i = 0; i < 80; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
        end
        for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Threshold change takes effect without a clock edge
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        af_thresh = 5'd5; ae_thresh = 5'd5;
        #1 check_all();
        af_thresh = 5'd6; ae_thresh = 5'd4;
        #1 check_all();
        af_thresh = 5'd14; ae_thresh = 5'd2;

        // Mid-stream reset discards contents
        do_reset();

        // Head-word visibility (meaningful in FWFT build, plain traffic otherwise)
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
